// File: rtl/lvds_rx_deser.sv
// Purpose : LVDS receive deserialiser. Retimes the serial bit stream, hunts for
//           SYNC_WORD at any bit offset, then emits word-aligned parallel data.
// Latency : a bit sampled on D reaches the sr LSB on the 3rd CE edge. The word
//           containing it is presented on the next CE edge after that.
// Backpr. : none. The stream is paced only by CE, and VALID is a one-cycle pulse
//           with no ready handshake.
//
// Ports:
//   CLK     rising-edge clock
//   RST_N   asynchronous active-low reset
//   CE      bit strobe; datapath, counters and word emission advance only when high
//   D       serial data from the LVDS input buffer (MSB of each word first)
//   RESYNC  synchronous drop-lock / re-hunt request, honoured on every CLK edge
//   DATA    last aligned word, earliest-received bit in the MSB
//   VALID   one-cycle pulse when DATA carries a new aligned word
//   IS_SYNC qualifies VALID: the emitted word equals SYNC_WORD
//   LOCKED  high while word alignment is held
//   LOST    one-cycle pulse when lock is dropped because of too many misses

module lvds_rx_deser #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5,
  parameter int               MAX_MISS  = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             D,
  input  logic             RESYNC,
  output logic [WIDTH-1:0] DATA,
  output logic             VALID,
  output logic             IS_SYNC,
  output logic             LOCKED,
  output logic             LOST
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // With loss detection disabled the miss counter still counts. It then
  // saturates at its full 8-bit range instead of at MAX_MISS.
  localparam logic [7:0] MISS_SAT = (MAX_MISS == 0) ? 8'hFF : 8'(MAX_MISS);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Retiming and shift register
  // ---------------------------------------------------------------------------
  logic             s1_q;
  logic             s2_q;
  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      sr_q <= '0;
    end else if (CE) begin
      s1_q <= D;
      s2_q <= s1_q;
      sr_q <= {sr_q[WIDTH-2:0], s2_q};
    end
  end

  // ---------------------------------------------------------------------------
  // Alignment FSM
  // ---------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] bit_cnt_d;
  logic [7:0]       miss_q;
  logic [7:0]       miss_d;
  logic [7:0]       miss_inc;
  logic             sync_hit;
  logic             emit;
  logic             emit_sync;
  logic             lost_d;

  // sr is compared once per CE edge. Each window is inspected exactly once,
  // on the CE edge after the one that completed it.
  assign sync_hit = (sr_q == SYNC_WORD);
  assign miss_inc = (miss_q == MISS_SAT) ? miss_q : miss_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    miss_d    = miss_q;
    emit      = 1'b0;
    emit_sync = 1'b0;
    lost_d    = 1'b0;

    if (RESYNC) begin
      // Overrides any match or boundary on this edge, with or without CE.
      state_d   = ST_HUNT;
      bit_cnt_d = '0;
      miss_d    = '0;
    end else if (CE) begin
      unique case (state_q)
        ST_HUNT: begin
          if (sync_hit) begin
            // The counter restarts here, so it reads LAST_BIT exactly WIDTH
            // CE edges later. That is when the next full aligned word sits in sr.
            state_d   = ST_LOCKED;
            bit_cnt_d = '0;
            miss_d    = '0;
            emit      = 1'b1;
            emit_sync = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            emit      = 1'b1;
            if (sync_hit) begin
              emit_sync = 1'b1;
              miss_d    = '0;
            end else begin
              miss_d = miss_inc;
              if ((MAX_MISS != 0) && (miss_inc == MISS_SAT)) begin
                lost_d  = 1'b1;
                state_d = ST_HUNT;
              end
            end
          end else begin
            // Sync patterns that appear off the aligned boundary are ignored.
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_HUNT;
      bit_cnt_q <= '0;
      miss_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      miss_q    <= miss_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers. The pulses are rewritten on every CLK edge, so they
  // cannot stay high across a cycle without a CE update.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             is_sync_q;
  logic             lost_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      is_sync_q <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      valid_q   <= emit;
      is_sync_q <= emit_sync;
      lost_q    <= lost_d;
      if (emit) begin
        data_q <= sr_q;
      end
    end
  end

  assign DATA    = data_q;
  assign VALID   = valid_q;
  assign IS_SYNC = is_sync_q;
  assign LOST    = lost_q;
  assign LOCKED  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_lvds_rx_deser.sv
// Bench for lvds_rx_deser. A bit-history model predicts every output on every
// cycle, and the tests pin that model with hand-computed literal expectations.
module tb_lvds_rx_deser;

  localparam int         W        = 8;
  localparam logic [7:0] SYNC     = 8'hA5;
  localparam int         MAX_MISS = 4;

  logic       CLK = 1'b0;
  logic       RST_N, CE, D, RESYNC;
  logic [7:0] DATA;
  logic       VALID, IS_SYNC, LOCKED, LOST;

  lvds_rx_deser #(.WIDTH(W), .SYNC_WORD(SYNC), .MAX_MISS(MAX_MISS)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .D(D), .RESYNC(RESYNC),
    .DATA(DATA), .VALID(VALID), .IS_SYNC(IS_SYNC), .LOCKED(LOCKED), .LOST(LOST)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int clk_cnt = 0;
  always @(posedge CLK) clk_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model. hist[0] holds the bit sampled on the previous CE edge, hist[1] the
  // one before that, and so on. The word judged on CE edge k is made of the
  // bits sampled on edges k-10 .. k-3.
  // ---------------------------------------------------------------------------
  logic [63:0] hist;
  logic [7:0]  m_data, win;
  bit          m_valid, m_sync, m_lost, m_locked;
  int          m_to_bnd, m_miss;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hist = '0; m_data = '0; m_valid = 0; m_sync = 0; m_lost = 0;
      m_locked = 0; m_to_bnd = 0; m_miss = 0;
    end else begin
      m_valid = 0; m_sync = 0; m_lost = 0;
      win = hist[9:2];
      if (RESYNC) begin
        m_locked = 0; m_miss = 0;
      end else if (CE) begin
        if (!m_locked) begin
          if (win == SYNC) begin
            m_locked = 1; m_to_bnd = W; m_miss = 0;
            m_valid = 1; m_sync = 1; m_data = win;
          end
        end else begin
          m_to_bnd--;
          if (m_to_bnd == 0) begin
            m_to_bnd = W; m_valid = 1; m_data = win;
            if (win == SYNC) begin
              m_sync = 1; m_miss = 0;
            end else begin
              m_miss++;
              if (m_miss == MAX_MISS) begin
                m_lost = 1; m_locked = 0;
              end
            end
          end
        end
      end
      if (CE) hist = {hist[62:0], D};
    end
  end

  // Per-cycle compare plus event log
  int         v_cyc[$];
  logic [7:0] v_dat[$];
  bit         v_sync[$];
  int         l_cyc[$];

  always @(negedge CLK) begin
    chk("cyc_VALID",   VALID,   m_valid);
    chk("cyc_IS_SYNC", IS_SYNC, m_sync);
    chk("cyc_LOST",    LOST,    m_lost);
    chk("cyc_LOCKED",  LOCKED,  m_locked);
    chk("cyc_DATA",    DATA,    m_data);
    if (VALID === 1'b1) begin
      v_cyc.push_back(clk_cnt); v_dat.push_back(DATA); v_sync.push_back(IS_SYNC);
    end
    if (LOST === 1'b1) l_cyc.push_back(clk_cnt);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Every task is entered 2 time units after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic send_bit(input logic b, input int gap);
    D = b; CE = 1'b1;
    @(posedge CLK); #2;
    for (int g = 0; g < gap; g++) begin
      CE = 1'b0;
      @(posedge CLK); #2;
    end
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic send_zeros(input int n, input int gap);
    for (int i = 0; i < n; i++) send_bit(1'b0, gap);
  endtask

  task automatic do_reset();
    RST_N = 1'b0; CE = 1'b0; D = 1'b0; RESYNC = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    v_cyc.delete(); v_dat.delete(); v_sync.delete(); l_cyc.delete();
  endtask

  int t0;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0; CE = 1'b0; D = 1'b0; RESYNC = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    do_reset();

    // ---- Reset mid-stream while locked ----
    send_zeros(3, 0); send_word(8'hA5, 0); send_zeros(3, 0);
    chk("rst_locked_before", LOCKED, 1);
    D = 1'b1; CE = 1'b1; RST_N = 1'b0;
    @(negedge CLK);
    chk("rst_async_locked", LOCKED, 0);
    chk("rst_async_data",   DATA,   0);
    chk("rst_async_valid",  VALID,  0);
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b1;
    v_cyc.delete(); l_cyc.delete();
    for (int i = 0; i < 24; i++) send_bit(1'b1, 0);
    CE = 1'b0;
    chk("rst_no_valid", v_cyc.size(), 0);

    // ---- Acquisition, CE held high ----
    do_reset(); t0 = clk_cnt;
    send_zeros(3, 0); send_word(8'hA5, 0); send_word(8'h3C, 0); send_word(8'hA5, 0);
    send_zeros(4, 0); CE = 1'b0;
    chk("acq_count", v_cyc.size(), 3);
    chk("acq_t0", v_cyc[0] - t0, 14);
    chk("acq_t1", v_cyc[1] - t0, 22);
    chk("acq_t2", v_cyc[2] - t0, 30);
    chk("acq_d0", v_dat[0], 8'hA5); chk("acq_s0", v_sync[0], 1);
    chk("acq_d1", v_dat[1], 8'h3C); chk("acq_s1", v_sync[1], 0);
    chk("acq_d2", v_dat[2], 8'hA5); chk("acq_s2", v_sync[2], 1);
    chk("acq_locked", LOCKED, 1);

    // ---- Same stream with CE alternating 1/0 ----
    do_reset(); t0 = clk_cnt;
    send_zeros(3, 1); send_word(8'hA5, 1); send_word(8'h3C, 1); send_word(8'hA5, 1);
    send_zeros(4, 1); CE = 1'b0;
    chk("gap_count", v_cyc.size(), 3);
    chk("gap_t0", v_cyc[0] - t0, 27);
    chk("gap_t1", v_cyc[1] - t0, 43);
    chk("gap_t2", v_cyc[2] - t0, 59);
    chk("gap_d1", v_dat[1], 8'h3C);
    chk("gap_d2", v_dat[2], 8'hA5);

    // ---- Loss of lock ----
    do_reset(); t0 = clk_cnt;
    send_zeros(3, 0);
    send_word(8'hA5, 0); send_word(8'h11, 0); send_word(8'h22, 0); send_word(8'h33, 0);
    send_word(8'hA5, 0); send_word(8'h44, 0); send_word(8'h55, 0); send_word(8'h66, 0);
    send_word(8'h77, 0); send_zeros(20, 0); CE = 1'b0;
    chk("loss_vcount", v_cyc.size(), 9);
    chk("loss_lcount", l_cyc.size(), 1);
    chk("loss_sync_mid", v_sync[4], 1);
    chk("loss_last_t", v_cyc[8] - t0, 78);
    chk("loss_last_d", v_dat[8], 8'h77);
    chk("loss_with_valid", l_cyc[0], v_cyc[8]);
    chk("loss_unlocked", LOCKED, 0);

    // ---- A5 offset by 3 bits while locked ----
    do_reset(); t0 = clk_cnt;
    send_zeros(3, 0); send_word(8'hA5, 0); send_word(8'h14, 0); send_word(8'hA0, 0);
    send_word(8'hA5, 0); send_zeros(4, 0); CE = 1'b0;
    chk("mis_count", v_cyc.size(), 4);
    chk("mis_d1", v_dat[1], 8'h14); chk("mis_s1", v_sync[1], 0);
    chk("mis_d2", v_dat[2], 8'hA0); chk("mis_s2", v_sync[2], 0);
    chk("mis_t3", v_cyc[3] - t0, 38);
    chk("mis_s3", v_sync[3], 1);
    chk("mis_nolost", l_cyc.size(), 0);
    chk("mis_locked", LOCKED, 1);

    // ---- RESYNC on the edge of an aligned A5 ----
    do_reset(); t0 = clk_cnt;
    fork
      begin
        send_zeros(3, 0);
        send_word(8'hA5, 0); send_word(8'h3C, 0); send_word(8'hA5, 0);
        send_word(8'h3C, 0); send_word(8'hA5, 0);
        send_zeros(4, 0); CE = 1'b0;
      end
      begin
        do begin @(posedge CLK); #1; end while (clk_cnt != t0 + 29);
        #1 RESYNC = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("rsy_no_valid", VALID, 0);
        chk("rsy_unlocked", LOCKED, 0);
        RESYNC = 1'b0;
      end
    join
    chk("rsy_count", v_cyc.size(), 3);
    chk("rsy_t1", v_cyc[1] - t0, 22);
    chk("rsy_t2", v_cyc[2] - t0, 46);
    chk("rsy_d2", v_dat[2], 8'hA5);
    chk("rsy_nolost", l_cyc.size(), 0);
    chk("rsy_relocked", LOCKED, 1);

    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
